clic_preempt_ctrl: RTL and testbench

Interrupt entry/exit sequencer between n_clic and the PC register. It accepts the CLIC's winning vector when its priority exceeds the current level, pushes the return PC and the old level onto a hardware frame stack, and redirects fetch to the vector. On mret it pops the frame, restores the level and returns. The current level is exported as the threshold that n_clic compares against, which gives nested (preemptive) interrupts.

---
 rtl/clic_pkg.sv | 27 ++
 rtl/clic_frame_stack.sv | 52 +++++
 rtl/clic_preempt_ctrl.sv | 177 +++++++++++++++++
 tb/tb_clic_preempt_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clic_pkg.sv
// Shared widths and types for the CLIC preemption controller and its frame stack.
package clic_pkg;

  localparam int unsigned IMemAddrWidth = 16;
  localparam int unsigned PrioWidth     = 3;
  localparam int unsigned VecWidth      = 3;
  localparam int unsigned NumVecs       = 2 ** VecWidth;
  localparam int unsigned PcWidth       = IMemAddrWidth;
  localparam int unsigned DefStackDepth = 4;

  typedef logic [PrioWidth-1:0] prio_t;
  typedef logic [VecWidth-1:0]  vec_t;
  typedef logic [PcWidth-1:0]   pc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAKE = 2'd1,
    JUMP = 2'd2,
    RET  = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    pc_t   pc;
    prio_t level;
  } frame_t;

endpackage

// File: rtl/clic_frame_stack.sv
// LIFO of interrupt frames; only the occupancy counter is reset, entries are don't-care.
module clic_frame_stack
  import clic_pkg::*;
#(
  parameter  int unsigned Depth  = DefStackDepth,
  localparam int unsigned DepthW = $clog2(Depth + 1),
  localparam int unsigned IdxW   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  frame_t            frame_i,
  output frame_t            top_o,
  output logic [DepthW-1:0] depth_o
);

  frame_t            mem_q [Depth];
  logic [DepthW-1:0] depth_q, depth_d;
  logic              full, empty;

  assign full  = (depth_q == DepthW'(Depth));
  assign empty = (depth_q == '0);

  // Saturating occupancy update; push wins if both are requested.
  always_comb begin
    depth_d = depth_q;
    if (push_i && !full) begin
      depth_d = depth_q + DepthW'(1);
    end else if (pop_i && !empty) begin
      depth_d = depth_q - DepthW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full) begin
      mem_q[IdxW'(depth_q)] <= frame_i;
    end
  end

  assign top_o   = mem_q[IdxW'(depth_q - DepthW'(1))];
  assign depth_o = depth_q;

endmodule

// File: rtl/clic_preempt_ctrl.sv
// Interrupt entry/exit sequencer: pushes return frames, redirects fetch, restores level on mret.
// Optional CLIC_TAIL_CHAIN_EN: a higher pend seen with mret reuses the top frame instead of returning.
module clic_preempt_ctrl
  import clic_pkg::*;
#(
  parameter  int unsigned StackDepth = DefStackDepth,
  localparam int unsigned DepthW     = $clog2(StackDepth + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_int,
  input  prio_t             max_prio,
  input  vec_t              max_vec,
  input  pc_t               vec_addr,
  input  pc_t               pc_in,
  input  logic              mret,
  output pc_t               pc_out,
  output logic              pc_sel,
  output prio_t             level,
  output logic              clear_pend,
  output vec_t              clear_vec,
  output logic [DepthW-1:0] depth,
  output logic              overflow
);

  ctrl_state_t       state_q, state_d;
  prio_t             prio_q, prio_d, level_q, level_d;
  pc_t               vaddr_q, vaddr_d, pc_out_q, pc_out_d;
  vec_t              clear_vec_q, clear_vec_d;
  logic              tail_q, tail_d;
  logic              pc_sel_q, pc_sel_d;
  logic              clear_pend_q, clear_pend_d;
  logic              overflow_q, overflow_d;
  logic              push, pop, full, ret_req, take_req, tail_now;
  frame_t            push_frame, top_frame;
  logic [DepthW-1:0] depth_w;

  assign push_frame = '{pc: pc_in, level: level_q};

  clic_frame_stack #(
    .Depth (StackDepth)
  ) u_stack (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .frame_i (push_frame),
    .top_o   (top_frame),
    .depth_o (depth_w)
  );

  assign full     = (depth_w == DepthW'(StackDepth));
  assign ret_req  = mret && (depth_w != '0);
  assign take_req = is_int && (max_prio > level_q);

`ifdef CLIC_TAIL_CHAIN_EN
  assign tail_now = is_int && (max_prio > top_frame.level);
`else
  assign tail_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Return has priority over a take; a full stack refuses the take.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ret_req) begin
          state_d = RET;
        end else if (take_req && !full) begin
          state_d = TAKE;
        end
      end
      TAKE:    state_d = JUMP;
      JUMP:    state_d = IDLE;
      RET:     state_d = tail_q ? JUMP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so they appear registered in the state they belong to.
  always_comb begin
    prio_d       = prio_q;
    vaddr_d      = vaddr_q;
    tail_d       = tail_q;
    level_d      = level_q;
    pc_out_d     = pc_out_q;
    clear_vec_d  = clear_vec_q;
    overflow_d   = overflow_q;
    pc_sel_d     = 1'b0;
    clear_pend_d = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ret_req) begin
          tail_d = tail_now;
          if (tail_now) begin
            prio_d       = max_prio;
            vaddr_d      = vec_addr;
            clear_pend_d = 1'b1;
            clear_vec_d  = max_vec;
          end else begin
            pc_sel_d = 1'b1;
            pc_out_d = top_frame.pc;
          end
        end else if (take_req) begin
          if (full) begin
            overflow_d = 1'b1;
          end else begin
            prio_d       = max_prio;
            vaddr_d      = vec_addr;
            clear_pend_d = 1'b1;
            clear_vec_d  = max_vec;
          end
        end
      end
      TAKE: begin
        push     = 1'b1;
        level_d  = prio_q;
        pc_sel_d = 1'b1;
        pc_out_d = vaddr_q;
      end
      RET: begin
        if (tail_q) begin
          level_d  = prio_q;
          pc_sel_d = 1'b1;
          pc_out_d = vaddr_q;
        end else begin
          pop     = 1'b1;
          level_d = top_frame.level;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q       <= '0;
      vaddr_q      <= '0;
      tail_q       <= 1'b0;
      level_q      <= '0;
      pc_out_q     <= '0;
      clear_vec_q  <= '0;
      overflow_q   <= 1'b0;
      pc_sel_q     <= 1'b0;
      clear_pend_q <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      vaddr_q      <= vaddr_d;
      tail_q       <= tail_d;
      level_q      <= level_d;
      pc_out_q     <= pc_out_d;
      clear_vec_q  <= clear_vec_d;
      overflow_q   <= overflow_d;
      pc_sel_q     <= pc_sel_d;
      clear_pend_q <= clear_pend_d;
    end
  end

  assign pc_out     = pc_out_q;
  assign pc_sel     = pc_sel_q;
  assign level      = level_q;
  assign clear_pend = clear_pend_q;
  assign clear_vec  = clear_vec_q;
  assign depth      = depth_w;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_clic_preempt_ctrl.sv
// Self-checking bench for clic_preempt_ctrl: directed scenarios plus a randomized run against a frame-queue model.
module tb_clic_preempt_ctrl;
  import clic_pkg::*;

  localparam int unsigned SD = 4;
  localparam int unsigned DW = $clog2(SD + 1);
`ifdef CLIC_TAIL_CHAIN_EN
  localparam bit TAIL = 1'b1;
`else
  localparam bit TAIL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          is_int = 1'b0;
  prio_t         max_prio = '0;
  vec_t          max_vec = '0;
  pc_t           vec_addr = '0;
  pc_t           pc_in = '0;
  logic          mret = 1'b0;
  pc_t           pc_out;
  logic          pc_sel;
  prio_t         level;
  logic          clear_pend;
  vec_t          clear_vec;
  logic [DW-1:0] depth;
  logic          overflow;

  int vectors = 0;
  int miscompares = 0;

  clic_preempt_ctrl #(.StackDepth(SD)) dut (
    .clk        (clk),
    .reset      (reset),
    .is_int     (is_int),
    .max_prio   (max_prio),
    .max_vec    (max_vec),
    .vec_addr   (vec_addr),
    .pc_in      (pc_in),
    .mret       (mret),
    .pc_out     (pc_out),
    .pc_sel     (pc_sel),
    .level      (level),
    .clear_pend (clear_pend),
    .clear_vec  (clear_vec),
    .depth      (depth),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of saved frames plus the running level and sticky overflow.
  typedef struct {
    pc_t   pc;
    prio_t lvl;
  } mframe_t;

  mframe_t       stk[$];
  prio_t         m_level;
  bit            m_ovf;
  bit            e_sel [3];
  bit            e_cp  [3];
  pc_t           e_pc  [3];
  vec_t          e_vec [3];
  prio_t         e_lvl [3];
  logic [DW-1:0] e_dep [3];
  bit            e_ovf [3];
  int            ncyc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    is_int = 1'b0;
    mret   = 1'b0;
  endtask

  task automatic pend(input prio_t pr, input vec_t v, input pc_t a);
    is_int   = 1'b1;
    max_prio = pr;
    max_vec  = v;
    vec_addr = a;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // Full entry sequence from IDLE back to IDLE, no checks.
  task automatic take_seq(input prio_t pr, input vec_t v, input pc_t a);
    pend(pr, v, a);
    step();
    clr_in();
    step();
    step();
  endtask

  // Expected per-cycle outputs for one request issued from IDLE.
  task automatic predict(input bit ii, input bit mr, input prio_t pr, input vec_t v,
                         input pc_t a, input pc_t pcin);
    mframe_t f;
    for (int c = 0; c < 3; c++) begin
      e_sel[c] = 1'b0;
      e_cp[c]  = 1'b0;
      e_pc[c]  = '0;
      e_vec[c] = '0;
      e_lvl[c] = m_level;
      e_dep[c] = DW'(stk.size());
      e_ovf[c] = m_ovf;
    end
    ncyc = 1;
    if (mr && stk.size() > 0) begin
      f = stk[$];
      if (TAIL && ii && (pr > f.lvl)) begin
        m_level  = pr;
        e_cp[0]  = 1'b1;
        e_vec[0] = v;
        e_sel[1] = 1'b1;
        e_pc[1]  = a;
        e_lvl[1] = pr;
        e_lvl[2] = pr;
        ncyc     = 3;
      end else begin
        f        = stk.pop_back();
        m_level  = f.lvl;
        e_sel[0] = 1'b1;
        e_pc[0]  = f.pc;
        e_lvl[1] = m_level;
        e_dep[1] = DW'(stk.size());
        ncyc     = 2;
      end
    end else if (ii && (pr > m_level)) begin
      if (stk.size() < SD) begin
        stk.push_back('{pc: pcin, lvl: m_level});
        m_level  = pr;
        e_cp[0]  = 1'b1;
        e_vec[0] = v;
        e_sel[1] = 1'b1;
        e_pc[1]  = a;
        for (int c = 1; c < 3; c++) begin
          e_lvl[c] = pr;
          e_dep[c] = DW'(stk.size());
        end
        ncyc = 3;
      end else begin
        m_ovf = 1'b1;
        e_ovf[0] = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    vectors++;
    if ({pc_out, clear_vec} !== {PcWidth'(0), VecWidth'(0)}) begin
      miscompares++;
      $display("FAIL reset_regs pc_out=%h clear_vec=%0d expected 0 0", pc_out, clear_vec);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if ({pc_sel, clear_pend, level, depth, overflow} !== {1'b0, 1'b0, PrioWidth'(0), DW'(0), 1'b0}) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d sel=%b cp=%b lvl=%0d dep=%0d ovf=%b expected all 0",
                 i, pc_sel, clear_pend, level, depth, overflow);
      end
    end
  endtask

  task automatic test_single_take();
    do_reset();
    pc_in = 16'h0010;
    pend(3'd1, 3'd4, 16'h0020);
    step();
    vectors++;
    if ({clear_pend, clear_vec, pc_sel} !== {1'b1, 3'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL take_ack cp=%b vec=%0d sel=%b expected 1 4 0", clear_pend, clear_vec, pc_sel);
    end
    clr_in();
    step();
    vectors++;
    if ({pc_sel, pc_out, level, depth, clear_pend} !== {1'b1, 16'h0020, 3'd1, DW'(1), 1'b0}) begin
      miscompares++;
      $display("FAIL take_jump sel=%b pc=%h lvl=%0d dep=%0d cp=%b expected 1 0020 1 1 0",
               pc_sel, pc_out, level, depth, clear_pend);
    end
    step();
    mret = 1'b1;
    step();
    vectors++;
    if ({pc_sel, pc_out} !== {1'b1, 16'h0010}) begin
      miscompares++;
      $display("FAIL ret_redirect sel=%b pc=%h expected 1 0010", pc_sel, pc_out);
    end
    clr_in();
    step();
    vectors++;
    if ({pc_sel, level, depth} !== {1'b0, 3'd0, DW'(0)}) begin
      miscompares++;
      $display("FAIL ret_restore sel=%b lvl=%0d dep=%0d expected 0 0 0", pc_sel, level, depth);
    end
  endtask

  task automatic test_nesting();
    do_reset();
    pc_in = 16'h0010;
    take_seq(3'd1, 3'd4, 16'h0020);
    pc_in = 16'h0024;
    pend(3'd7, 3'd7, 16'h0038);
    step();
    vectors++;
    if ({clear_pend, clear_vec} !== {1'b1, 3'd7}) begin
      miscompares++;
      $display("FAIL nest_ack cp=%b vec=%0d expected 1 7", clear_pend, clear_vec);
    end
    clr_in();
    step();
    vectors++;
    if ({pc_sel, pc_out, level, depth} !== {1'b1, 16'h0038, 3'd7, DW'(2)}) begin
      miscompares++;
      $display("FAIL nest_jump sel=%b pc=%h lvl=%0d dep=%0d expected 1 0038 7 2", pc_sel, pc_out, level, depth);
    end
    step();
    pend(3'd2, 3'd2, 16'h0010);
    step();
    vectors++;
    if ({clear_pend, pc_sel, level, depth} !== {1'b0, 1'b0, 3'd7, DW'(2)}) begin
      miscompares++;
      $display("FAIL nest_lowprio cp=%b sel=%b lvl=%0d dep=%0d expected 0 0 7 2", clear_pend, pc_sel, level, depth);
    end
    clr_in();
    mret = 1'b1;
    step();
    vectors++;
    if ({pc_sel, pc_out} !== {1'b1, 16'h0024}) begin
      miscompares++;
      $display("FAIL nest_ret sel=%b pc=%h expected 1 0024", pc_sel, pc_out);
    end
    clr_in();
    step();
    vectors++;
    if ({level, depth} !== {3'd1, DW'(1)}) begin
      miscompares++;
      $display("FAIL nest_restore lvl=%0d dep=%0d expected 1 1", level, depth);
    end
  endtask

  task automatic test_equal_prio();
    do_reset();
    take_seq(3'd2, 3'd3, 16'h0018);
    pend(3'd2, 3'd5, 16'h0028);
    step();
    vectors++;
    if ({clear_pend, pc_sel, level, depth} !== {1'b0, 1'b0, 3'd2, DW'(1)}) begin
      miscompares++;
      $display("FAIL equal_prio cp=%b sel=%b lvl=%0d dep=%0d expected 0 0 2 1", clear_pend, pc_sel, level, depth);
    end
    clr_in();
    step();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 4; k++) take_seq(prio_t'(k), vec_t'(k), pc_t'(8 * k));
    vectors++;
    if ({depth, level, overflow} !== {DW'(4), 3'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL ovf_fill dep=%0d lvl=%0d ovf=%b expected 4 4 0", depth, level, overflow);
    end
    pend(3'd5, 3'd5, 16'h0028);
    step();
    vectors++;
    if ({overflow, clear_pend, pc_sel, depth} !== {1'b1, 1'b0, 1'b0, DW'(4)}) begin
      miscompares++;
      $display("FAIL ovf_refuse ovf=%b cp=%b sel=%b dep=%0d expected 1 0 0 4", overflow, clear_pend, pc_sel, depth);
    end
    clr_in();
    step();
    step();
    vectors++;
    if ({overflow, pc_sel, level} !== {1'b1, 1'b0, 3'd4}) begin
      miscompares++;
      $display("FAIL ovf_sticky ovf=%b sel=%b lvl=%0d expected 1 0 4", overflow, pc_sel, level);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pc_in = 16'h0010;
    take_seq(3'd1, 3'd4, 16'h0020);
    pc_in = 16'h0024;
    pend(3'd7, 3'd7, 16'h0038);
    mret = 1'b1;
    step();
`ifdef CLIC_TAIL_CHAIN_EN
    vectors++;
    if ({pc_sel, clear_pend, clear_vec} !== {1'b0, 1'b1, 3'd7}) begin
      miscompares++;
      $display("FAIL tail_ack sel=%b cp=%b vec=%0d expected 0 1 7", pc_sel, clear_pend, clear_vec);
    end
    clr_in();
    step();
`else
    vectors++;
    if ({pc_sel, pc_out, clear_pend} !== {1'b1, 16'h0010, 1'b0}) begin
      miscompares++;
      $display("FAIL simul_ret sel=%b pc=%h cp=%b expected 1 0010 0", pc_sel, pc_out, clear_pend);
    end
    mret = 1'b0;
    step();
    vectors++;
    if ({pc_sel, level, depth} !== {1'b0, 3'd0, DW'(0)}) begin
      miscompares++;
      $display("FAIL simul_restore sel=%b lvl=%0d dep=%0d expected 0 0 0", pc_sel, level, depth);
    end
    step();
    vectors++;
    if ({clear_pend, clear_vec} !== {1'b1, 3'd7}) begin
      miscompares++;
      $display("FAIL simul_retake cp=%b vec=%0d expected 1 7", clear_pend, clear_vec);
    end
    clr_in();
    step();
`endif
    vectors++;
    if ({pc_sel, pc_out, level, depth} !== {1'b1, 16'h0038, 3'd7, DW'(1)}) begin
      miscompares++;
      $display("FAIL simul_jump sel=%b pc=%h lvl=%0d dep=%0d expected 1 0038 7 1", pc_sel, pc_out, level, depth);
    end
    step();
  endtask

  task automatic test_reset_abort();
    do_reset();
    take_seq(3'd2, 3'd1, 16'h0008);
    pend(3'd5, 3'd6, 16'h0030);
    step();
    reset = 1'b0;
    #1;
    vectors++;
    if ({depth, level, clear_pend, pc_sel} !== {DW'(0), 3'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_take dep=%0d lvl=%0d cp=%b sel=%b expected 0 0 0 0", depth, level, clear_pend, pc_sel);
    end
    clr_in();
    step();
    reset = 1'b1;
    step();
    step();
    vectors++;
    if ({depth, level, pc_sel} !== {DW'(0), 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_after dep=%0d lvl=%0d sel=%b expected 0 0 0", depth, level, pc_sel);
    end
  endtask

  task automatic test_random(input int n);
    bit    ii, mr;
    prio_t pr;
    vec_t  v;
    pc_t   a, p;
    do_reset();
    stk.delete();
    m_level = '0;
    m_ovf   = 1'b0;
    for (int it = 0; it < n; it++) begin
      ii = ($urandom_range(9) < 6);
      mr = ($urandom_range(9) < 3);
      pr = prio_t'($urandom);
      v  = vec_t'($urandom);
      a  = pc_t'($urandom);
      p  = pc_t'($urandom);
      is_int = ii; mret = mr; max_prio = pr; max_vec = v; vec_addr = a; pc_in = p;
      predict(ii, mr, pr, v, a, p);
      for (int c = 0; c < ncyc; c++) begin
        step();
        if (c == 0) clr_in();
        vectors++;
        if ({pc_sel, clear_pend, level, depth, overflow} !== {e_sel[c], e_cp[c], e_lvl[c], e_dep[c], e_ovf[c]}) begin
          miscompares++;
          $display("FAIL rand_ctl it=%0d cyc=%0d sel/cp/lvl/dep/ovf=%b %b %0d %0d %b expected %b %b %0d %0d %b",
                   it, c, pc_sel, clear_pend, level, depth, overflow,
                   e_sel[c], e_cp[c], e_lvl[c], e_dep[c], e_ovf[c]);
        end
        if (e_sel[c]) begin
          vectors++;
          if (pc_out !== e_pc[c]) begin
            miscompares++;
            $display("FAIL rand_pc it=%0d cyc=%0d pc_out=%h expected %h", it, c, pc_out, e_pc[c]);
          end
        end
        if (e_cp[c]) begin
          vectors++;
          if (clear_vec !== e_vec[c]) begin
            miscompares++;
            $display("FAIL rand_vec it=%0d cyc=%0d clear_vec=%0d expected %0d", it, c, clear_vec, e_vec[c]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_take();
    test_nesting();
    test_equal_prio();
    test_overflow();
    test_simultaneous();
    test_reset_abort();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
